// File: rtl/servo_pose_sequencer.sv
// -----------------------------------------------------------------------------
// servo_pose_sequencer
//
// Keyframe scheduler for the biped leg servos. A small pose table holds one
// target angle per servo plus a dwell time (in ticks) for each frame. During
// playback every channel ramps toward the active pose by at most STEP_DEG
// degrees per servo-frame tick. The pose is then held for its dwell time, and
// playback advances to the next frame.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_start        one-cycle pulse, begins playback at frame 0 when idle
//   i_stop         one-cycle pulse, aborts playback and holds current angles
//   i_loop_en      wrap from the last frame to frame 0 (sampled in NEXT)
//   i_last_frame   index of the final frame to play
//   i_cfg_we       pose table write enable (ignored while busy)
//   i_cfg_addr     pose table write address
//   i_cfg_angles   packed target angles, channel 0 in bits [7:0]
//   i_cfg_dwell    ticks to hold the pose once reached
//   i_pause        (SERVO_SEQ_PAUSE_EN only) freeze tick counter and FSM
//   o_angle_out    packed commanded angles, 0..180 degrees
//   o_angle_strobe one-cycle pulse while o_angle_out shows a new value
//   o_frame_idx    frame currently targeted
//   o_busy         high in any state other than IDLE
//   o_seq_done     one-cycle pulse when non-looping playback completes
//
// Build option: define SERVO_SEQ_PAUSE_EN to add the i_pause input.
// -----------------------------------------------------------------------------
module servo_pose_sequencer #(
  parameter int NUM_SERVO  = 6,
  parameter int FRAMES     = 16,
  parameter int TICK_CLKS  = 1000000,
  parameter int STEP_DEG   = 2,
  parameter int HOME_ANGLE = 90
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_loop_en,
  input  logic [$clog2(FRAMES)-1:0]    i_last_frame,
  input  logic                         i_cfg_we,
  input  logic [$clog2(FRAMES)-1:0]    i_cfg_addr,
  input  logic [NUM_SERVO*8-1:0]       i_cfg_angles,
  input  logic [7:0]                   i_cfg_dwell,
`ifdef SERVO_SEQ_PAUSE_EN
  input  logic                         i_pause,
`endif
  output logic [NUM_SERVO*8-1:0]       o_angle_out,
  output logic                         o_angle_strobe,
  output logic [$clog2(FRAMES)-1:0]    o_frame_idx,
  output logic                         o_busy,
  output logic                         o_seq_done
);

  localparam int ADDR_W = $clog2(FRAMES);
  localparam int CNT_W  = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int AW     = NUM_SERVO * 8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RAMP, S_DWELL, S_NEXT} state_t;

  state_t              r_state, w_state_next;
  logic [AW-1:0]       r_angle, r_target, w_angle_next, w_cfg_clamped;
  logic [7:0]          r_dwell, r_dwell_cnt;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic [ADDR_W-1:0]   r_frame_idx;
  logic                r_strobe, r_seq_done;
  logic                w_pause, w_stop_act, w_tick, w_all_done, w_dwell_done;
  logic                w_more, w_wrap;

  logic [AW-1:0]       r_tab_ang   [FRAMES];
  logic [7:0]          r_tab_dwell [FRAMES];

`ifdef SERVO_SEQ_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  // One bounded step toward the target; never overshoots, so the result stays
  // within the 0..180 range of the (clamped) target.
  function automatic logic [7:0] step_toward(input logic [7:0] a, input logic [7:0] t);
    int d;
    d = int'(t) - int'(a);
    if (d > STEP_DEG)       step_toward = a + 8'(STEP_DEG);
    else if (-d > STEP_DEG) step_toward = a - 8'(STEP_DEG);
    else                    step_toward = t;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_angle_next  = r_angle;
    w_cfg_clamped = i_cfg_angles;
    for (int ch = 0; ch < NUM_SERVO; ch++) begin
      w_angle_next[ch*8 +: 8] = step_toward(r_angle[ch*8 +: 8], r_target[ch*8 +: 8]);
      if (i_cfg_angles[ch*8 +: 8] > 8'd180) w_cfg_clamped[ch*8 +: 8] = 8'd180;
    end
  end

  assign w_stop_act   = i_stop && (r_state != S_IDLE);
  assign w_tick       = (r_state == S_RAMP || r_state == S_DWELL) && !w_pause &&
                        (r_tick_cnt == CNT_W'(TICK_CLKS - 1));
  assign w_all_done   = (w_angle_next == r_target);
  // Zero dwell leaves DWELL after one cycle without waiting for a tick.
  assign w_dwell_done = (r_dwell == 8'd0) || (w_tick && (r_dwell_cnt + 8'd1 == r_dwell));
  assign w_more       = (r_frame_idx < i_last_frame);
  assign w_wrap       = (r_frame_idx == i_last_frame) && i_loop_en;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic. stop overrides everything, pause freezes everything else.
  always_comb begin
    w_state_next = r_state;
    if (w_stop_act) begin
      w_state_next = S_IDLE;
    end else if (!w_pause) begin
      unique case (r_state)
        S_IDLE:  if (i_start && !i_stop) w_state_next = S_LOAD;
        S_LOAD:  w_state_next = S_RAMP;
        S_RAMP:  if (w_tick && w_all_done) w_state_next = S_DWELL;
        S_DWELL: if (w_dwell_done) w_state_next = S_NEXT;
        S_NEXT:  w_state_next = (w_more || w_wrap) ? S_LOAD : S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  // Datapath: angles, targets, counters and frame index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_angle     <= {NUM_SERVO{8'(HOME_ANGLE)}};
      r_target    <= {NUM_SERVO{8'(HOME_ANGLE)}};
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_tick_cnt  <= '0;
      r_frame_idx <= '0;
      r_strobe    <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_seq_done <= 1'b0;
      if (!w_stop_act && !w_pause) begin
        unique case (r_state)
          S_IDLE:  if (i_start && !i_stop) r_frame_idx <= '0;
          S_LOAD: begin
            r_target    <= r_tab_ang[r_frame_idx];
            r_dwell     <= r_tab_dwell[r_frame_idx];
            r_dwell_cnt <= '0;
          end
          S_RAMP: if (w_tick) begin
            r_angle  <= w_angle_next;
            r_strobe <= (w_angle_next != r_angle);
          end
          S_DWELL: if (w_tick) r_dwell_cnt <= r_dwell_cnt + 8'd1;
          S_NEXT: begin
            if (w_more)      r_frame_idx <= r_frame_idx + 1'b1;
            else if (w_wrap) r_frame_idx <= '0;
            else             r_seq_done  <= 1'b1;
          end
          default: ;
        endcase
        // Tick counter runs only in RAMP/DWELL and is cleared elsewhere, so
        // each RAMP entry starts a full TICK_CLKS interval.
        if (r_state == S_RAMP || r_state == S_DWELL)
          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        else
          r_tick_cnt <= '0;
      end
    end
  end

  // Pose table, writable only while idle.
  // NOTE: the table is plain storage with no reset, so it can map to RAM;
  // its contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && r_state == S_IDLE) begin
      r_tab_ang[i_cfg_addr]   <= w_cfg_clamped;
      r_tab_dwell[i_cfg_addr] <= i_cfg_dwell;
    end
  end

  assign o_angle_out    = r_angle;
  assign o_angle_strobe = r_strobe;
  assign o_frame_idx    = r_frame_idx;
  assign o_seq_done     = r_seq_done;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
`timescale 1ns/1ps
module tb_servo_pose_sequencer;

  localparam int NS = 2, FR = 16, T = 4, STEP = 10, HOME = 90, MAXC = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0, cfg_we = 1'b0;
  logic [3:0]  last_frame = '0, cfg_addr = '0;
  logic [15:0] cfg_angles = '0;
  logic [7:0]  cfg_dwell = '0;
`ifdef SERVO_SEQ_PAUSE_EN
  logic        pause = 1'b0;
`endif
  logic [15:0] angle_out;
  logic        angle_strobe, busy, seq_done;
  logic [3:0]  frame_idx;

  always #5 clk = ~clk;

  servo_pose_sequencer #(
    .NUM_SERVO(NS), .FRAMES(FR), .TICK_CLKS(T), .STEP_DEG(STEP), .HOME_ANGLE(HOME)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
    .i_loop_en(loop_en), .i_last_frame(last_frame),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_angles(cfg_angles),
    .i_cfg_dwell(cfg_dwell),
`ifdef SERVO_SEQ_PAUSE_EN
    .i_pause(pause),
`endif
    .o_angle_out(angle_out), .o_angle_strobe(angle_strobe),
    .o_frame_idx(frame_idx), .o_busy(busy), .o_seq_done(seq_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
    end
  endtask

  // ---------------- behavioural model: expected output timeline ------------
  int exp_a  [MAXC][NS];
  int exp_fr [MAXC];
  bit exp_st [MAXC];
  bit exp_busy [MAXC];
  bit exp_done [MAXC];
  int m_tab  [FR][NS];
  int m_dwell[FR];
  int m_cur  [NS];

  function automatic logic [15:0] pack_ang(int c);
    logic [15:0] r;
    for (int ch = 0; ch < NS; ch++) r[ch*8 +: 8] = 8'(exp_a[c][ch]);
    return r;
  endfunction

  function automatic void copy_c(int dst, int src);
    for (int ch = 0; ch < NS; ch++) exp_a[dst][ch] = exp_a[src][ch];
    exp_fr[dst] = exp_fr[src]; exp_st[dst] = exp_st[src];
    exp_busy[dst] = exp_busy[src]; exp_done[dst] = exp_done[src];
  endfunction

  // Idle from cycle c on, holding the outputs shown in cycle c-1.
  function automatic void hold_from(int c);
    for (int k = c; k < MAXC; k++) begin
      copy_c(k, c - 1);
      exp_st[k] = 1'b0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
    end
  endfunction

  // Busy segment of len cycles showing m_cur; st marks a fresh angle update.
  function automatic void seg(int c, int len, int f, bit st);
    for (int j = 0; j < len; j++) begin
      if (c + j < MAXC) begin
        for (int ch = 0; ch < NS; ch++) exp_a[c+j][ch] = m_cur[ch];
        exp_st[c+j] = (j == 0) ? st : 1'b0;
        exp_fr[c+j] = f; exp_busy[c+j] = 1'b1; exp_done[c+j] = 1'b0;
      end
    end
  endfunction

  // Playback accepted with start seen in cycle p.
  // Per frame: LOAD 1 cycle, ceil(max|delta|/STEP) ticks (at least one) of T
  // cycles, dwell*T cycles (or 1 if zero), NEXT 1 cycle.
  function automatic void play(int p, int last, bit lp);
    int c, f, n, need, diff, len;
    bit st;
    c = p + 1; f = 0;
    for (int ch = 0; ch < NS; ch++) m_cur[ch] = exp_a[p][ch];
    while (c < MAXC) begin
      seg(c, 1, f, 1'b0); c++;
      n = 1;
      for (int ch = 0; ch < NS; ch++) begin
        diff = m_tab[f][ch] - m_cur[ch];
        need = ((diff < 0 ? -diff : diff) + STEP - 1) / STEP;
        if (need > n) n = need;
      end
      st = 1'b0;
      for (int k = 0; k < n; k++) begin
        seg(c, T, f, st); c += T;
        st = 1'b0;
        for (int ch = 0; ch < NS; ch++) begin
          diff = m_tab[f][ch] - m_cur[ch];
          if (diff > 0)      begin m_cur[ch] += (diff < STEP) ? diff : STEP; st = 1'b1; end
          else if (diff < 0) begin m_cur[ch] -= (-diff < STEP) ? -diff : STEP; st = 1'b1; end
        end
      end
      len = (m_dwell[f] == 0) ? 1 : m_dwell[f] * T;
      seg(c, len, f, st); c += len;
      seg(c, 1, f, 1'b0); c++;
      if (f < last) f++;
      else if (lp)  f = 0;
      else begin
        if (c < MAXC) begin hold_from(c); exp_done[c] = 1'b1; end
        return;
      end
    end
  endfunction

  // Pause visible in cycles q+1..q+len-... : edges q+1..q+len do nothing.
  function automatic void pause_shift(int q, int len);
    for (int k = MAXC - 1; k > q + len; k--) copy_c(k, k - len);
    for (int k = q + 1; k <= q + len; k++) begin
      copy_c(k, q); exp_st[k] = 1'b0; exp_done[k] = 1'b0;
    end
  endfunction

  // ---------------- per-cycle compare -------------------------------------
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("angle_out", angle_out, pack_ang(cyc));
      check("angle_strobe", angle_strobe, exp_st[cyc]);
      check("frame_idx", frame_idx, exp_fr[cyc]);
      check("busy", busy, exp_busy[cyc]);
      check("seq_done", seq_done, exp_done[cyc]);
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  int last_p = 0;

  task automatic at_cycle(int c);
    while (1) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  task automatic do_write(int addr, int a0, int a1, int d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 4'(addr);
    cfg_angles = {8'(a1), 8'(a0)}; cfg_dwell = 8'(d);
    if (!exp_busy[cyc]) begin
      m_tab[addr][0] = (a0 > 180) ? 180 : a0;
      m_tab[addr][1] = (a1 > 180) ? 180 : a1;
      m_dwell[addr]  = d;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse(bit s, bit p);
    @(posedge clk); #1;
    start = s; stop = p; last_p = cyc;
    if (p) begin
      if (exp_busy[cyc]) hold_from(cyc + 1);
    end else if (s && !exp_busy[cyc]) begin
      play(cyc, int'(last_frame), loop_en);
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    for (int k = 0; k < MAXC; k++) begin
      for (int ch = 0; ch < NS; ch++) exp_a[k][ch] = HOME;
      exp_fr[k] = 0; exp_st[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
    end
    for (int f = 0; f < FR; f++) begin
      m_tab[f][0] = 0; m_tab[f][1] = 0; m_dwell[f] = 0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0; chk_en = 1'b1;

    // 1: reset state, then start is accepted and aborted before any tick
    check("reset angle_out", angle_out, 16'h5A5A);
    check("reset busy", busy, 1'b0);
    check("reset frame_idx", frame_idx, 4'd0);
    pulse(1'b1, 1'b0);
    check("busy after start", busy, 1'b1);
    pulse(1'b0, 1'b1);

    // 2: single frame, three strobes 4 cycles apart, 8-cycle dwell, done
    do_write(0, 120, 60, 2);
    last_frame = 4'd0; loop_en = 1'b0;
    pulse(1'b1, 1'b0); p = last_p;
    at_cycle(p + 6);  check("t2 step1", angle_out, 16'h5064); check("t2 strobe1", angle_strobe, 1'b1);
    at_cycle(p + 10); check("t2 step2", angle_out, 16'h466E);
    at_cycle(p + 14); check("t2 step3", angle_out, 16'h3C78);
    at_cycle(p + 22); check("t2 busy in NEXT", busy, 1'b1);
    at_cycle(p + 23); check("t2 seq_done", seq_done, 1'b1); check("t2 idle", busy, 1'b0);

    // 3: clamping and no overshoot over two frames
    do_write(1, 200, 5, 0);
    do_write(0, 0, 0, 0);
    last_frame = 4'd1;
    pulse(1'b1, 1'b0); p = last_p;
    at_cycle(p + 57);  check("t3 ch1 final step 5", angle_out, 16'h050A);
    at_cycle(p + 127); check("t3 end angles", angle_out, 16'h05B4); check("t3 seq_done", seq_done, 1'b1);

    // 4+5: looping, ignored write/start while busy, stop mid-RAMP
    do_write(0, 60, 20, 0);
    loop_en = 1'b1;
    pulse(1'b1, 1'b0); p = last_p;
    at_cycle(p + 52);  check("t4 frame 1", frame_idx, 4'd1);
    at_cycle(p + 59);  do_write(0, 10, 10, 5);
    at_cycle(p + 69);  pulse(1'b1, 1'b0);
    at_cycle(p + 103); check("t4 wrap to frame 0", frame_idx, 4'd0);
    at_cycle(p + 129); pulse(1'b0, 1'b1);
    at_cycle(p + 131); check("t4 idle after stop", busy, 1'b0);
    at_cycle(p + 140); check("t4 frozen angles", angle_out, 16'h1478); check("t4 no done", seq_done, 1'b0);

    pulse(1'b1, 1'b1);
    check("t5 start+stop idle", busy, 1'b0);
    loop_en = 1'b0; last_frame = 4'd0;
    pulse(1'b1, 1'b0); p = last_p;
    at_cycle(p + 28); check("t5 table kept", angle_out, 16'h143C); check("t5 seq_done", seq_done, 1'b1);

`ifdef SERVO_SEQ_PAUSE_EN
    // 6: pause for 10 cycles mid-RAMP shifts the next strobe by 10
    do_write(0, 100, 20, 0);
    pulse(1'b1, 1'b0); p = last_p;
    at_cycle(p + 6);
    @(posedge clk); #1;
    pause = 1'b1; pause_shift(cyc, 10);
    repeat (10) @(posedge clk);
    #1 pause = 1'b0;
    at_cycle(p + 19); check("t6 no early strobe", angle_strobe, 1'b0);
    at_cycle(p + 20); check("t6 strobe after pause", angle_strobe, 1'b1);
    check("t6 angle", angle_out, 16'h1450);
    at_cycle(p + 35);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/servo_pose_sequencer.md
Name: servo_pose_sequencer

Overview:
Keyframe scheduler for the biped leg servos. It holds a small table of poses, where each pose is one target angle per servo plus a dwell time. It ramps every channel's commanded angle toward the active pose at a bounded slew rate, one step per servo frame. Its angle outputs feed the per-channel angle-to-pulse-width conversion and PWM generators, and it replaces the single push-button speed/angle controller.

Parameters:
NUM_SERVO, 6, number of servo channels sequenced in lockstep
FRAMES, 16, pose table depth (power of 2)
TICK_CLKS, 1000000, clocks per update tick (20 ms servo frame at 50 MHz)
STEP_DEG, 2, maximum angle change per channel per tick, in degrees
HOME_ANGLE, 90, reset/home angle for every channel

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins playback at frame 0 when idle
stop  in  1  one-cycle pulse; abort playback and hold current angles
loop_en  in  1  1 = wrap from last frame to frame 0; sampled at end of last frame
last_frame  in  log2(FRAMES)  index of final frame to play
cfg_we  in  1  pose table write enable
cfg_addr  in  log2(FRAMES)  pose table write address
cfg_angles  in  NUM_SERVO*8  packed target angles, channel 0 in bits [7:0]
cfg_dwell  in  8  ticks to hold the pose once reached
angle_out  out  NUM_SERVO*8  packed commanded angles (degrees, 0..180)
angle_strobe  out  1  one-cycle pulse when angle_out changed this cycle
frame_idx  out  log2(FRAMES)  frame currently targeted
busy  out  1  high in any state other than IDLE
seq_done  out  1  one-cycle pulse when non-looping playback completes

Behaviour:
- Reset: state IDLE; all angle_out channels = HOME_ANGLE; frame_idx = 0; busy = angle_strobe = seq_done = 0; tick counter = 0. Table contents are not reset.
- Table writes: accepted only when busy = 0; ignored while busy. Any written angle > 180 is stored as 180. Write takes effect on the next cycle.
- States: IDLE, LOAD, RAMP, DWELL, NEXT.
- IDLE: when start = 1 and stop = 0 → LOAD with frame_idx = 0; busy rises on the following cycle.
- LOAD (1 cycle): latch table[frame_idx] into the target and dwell registers; clear the tick counter → RAMP.
- Tick: the counter runs in RAMP and DWELL. tick = 1 on the cycle the counter equals TICK_CLKS-1; the counter then wraps to 0. The first tick occurs TICK_CLKS cycles after entering RAMP.
- RAMP: on each tick, every channel moves toward its target by min(STEP_DEG, |target-angle|). angle_strobe pulses on that same cycle if any channel changed.
  - If all channels equal their targets after the update → DWELL.
  - If all channels already equal their targets on RAMP entry, the FSM still waits for the first tick, then → DWELL with no strobe.
- DWELL: count ticks. When the dwell count is reached → NEXT. Dwell = 0 → NEXT on the cycle after entry, without waiting for a tick.
- NEXT (1 cycle):
  - frame_idx < last_frame → frame_idx+1, LOAD.
  - frame_idx == last_frame and loop_en = 1 → frame_idx = 0, LOAD.
  - Otherwise → IDLE and pulse seq_done.
- stop in any non-IDLE state → IDLE next cycle; angles hold their present values; no seq_done. stop wins over start when both are asserted.
- start while busy: ignored.
- Arithmetic: angles are 8-bit unsigned. Stepping never overshoots the target and never leaves 0..180. With STEP_DEG = 0, RAMP never completes; this is a legal, documented configuration that relies on stop.
- Ramp duration from angle a to target t is ceil(|t-a|/STEP_DEG) ticks.

Optional Feature:
SERVO_SEQ_PAUSE_EN
- Defined: adds input port pause (1 bit). While pause = 1 the tick counter freezes, no ticks occur, angles hold, and the FSM stays in its state. stop and reset still act immediately. Releasing pause resumes the count from the frozen value.
- Undefined: no pause port; the tick counter always runs in RAMP/DWELL.

Test Plan:
Parameters for the bench: TICK_CLKS = 4, STEP_DEG = 10, NUM_SERVO = 2.
1. Reset → angle_out = {90,90}, busy = 0, frame_idx = 0; then pulse start with table empty-checks skipped → busy = 1 within 2 cycles.
2. Table[0] = {120,60}, dwell 2, last_frame = 0, loop_en = 0; start → 3 strobes (100/80, 110/70, 120/60), each 4 cycles apart; then 8 cycles of dwell; then seq_done pulse and busy = 0.
3. Write {200,5} to table[1] → stored {180,5}. Play frames 0..1 from {0,0} → ch0 ends at 180 and ch1 at 5, with no overshoot (final ch1 step of 5).
4. loop_en = 1, last_frame = 1 → frame_idx sequence 0,1,0,1…; no seq_done; a stop mid-RAMP → IDLE next cycle, angles frozen, no seq_done.
5. cfg_we while busy → table unchanged, verified on the next playback. start and stop in the same cycle while idle → remains IDLE.
6. (SERVO_SEQ_PAUSE_EN) pause = 1 for 10 cycles mid-RAMP → no strobes during the pause; the next strobe arrives exactly (remaining count) cycles after release.
